// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard/sequencing controller.
// Holds the opcode map, stage record layout, forward-select encoding,
// controller FSM states and the register-match helper.
package mips_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 6'h00,
        OP_ADDI = 6'h01,
        OP_SUB  = 6'h02,
        OP_SUBI = 6'h03,
        OP_AND  = 6'h04,
        OP_ANDI = 6'h05,
        OP_OR   = 6'h06,
        OP_ORI  = 6'h07,
        OP_XOR  = 6'h08,
        OP_XORI = 6'h09,
        OP_SLT  = 6'h0A,
        OP_SLTI = 6'h0B,
        OP_LDW  = 6'h0C,
        OP_STW  = 6'h0D,
        OP_BZ   = 6'h0E,
        OP_BEQ  = 6'h0F,
        OP_JR   = 6'h10,
        OP_HALT = 6'h11
    } opcode_e;

    typedef struct packed {
        logic             valid;
        logic             wr_en;
        logic             is_load;
        logic             is_halt;
        logic [REG_W-1:0] dst;
    } stage_rec_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ctrl_state_e;

    // True when a stage record will write the given source register ($0 never matches).
    function automatic logic rec_hit(input stage_rec_t rec, input logic [REG_W-1:0] src);
        return rec.valid && rec.wr_en && (rec.dst == src) && (src != '0);
    endfunction

endpackage

// File: rtl/mips_pipe_ctrl_if.sv
// Datapath <-> pipeline controller bundle.
// master: datapath (drives ID fields and redirect, consumes enables/selects/status)
// slave : controller (mips_pipe_ctrl)
interface mips_pipe_ctrl_if
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    logic             id_valid;
    logic [OP_W-1:0]  id_opcode;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [REG_W-1:0] id_rd;
    logic             ex_redirect;
    logic             stall_if;
    logic             stall_id;
    logic             flush_id;
    logic             bubble_ex;
    logic [1:0]       ex_fwd_rs_sel;
    logic [1:0]       ex_fwd_rt_sel;
    logic             halted;
    logic             illegal_op;
    logic [CNT_W-1:0] retired_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, ex_redirect,
        input  stall_if, stall_id, flush_id, bubble_ex, ex_fwd_rs_sel, ex_fwd_rt_sel,
        input  halted, illegal_op, retired_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, ex_redirect,
        output stall_if, stall_id, flush_id, bubble_ex, ex_fwd_rs_sel, ex_fwd_rt_sel,
        output halted, illegal_op, retired_cnt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/mips_src_decode.sv
// Combinational ID-stage decode: which registers an instruction reads and writes.
// In : opcode_i, rt_i, rd_i
// Out: uses_rs_o, uses_rt_o, wr_en_o, dst_o, is_load_o, is_halt_o, illegal_o
module mips_src_decode
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]  opcode_i,
    input  logic [REG_W-1:0] rt_i,
    input  logic [REG_W-1:0] rd_i,
    output logic             uses_rs_o,
    output logic             uses_rt_o,
    output logic             wr_en_o,
    output logic [REG_W-1:0] dst_o,
    output logic             is_load_o,
    output logic             is_halt_o,
    output logic             illegal_o
);

    logic wr;

    // ALU ops: even opcodes are R-type (rs,rt -> rd), odd are I-type (rs -> rt).
    always_comb begin
        uses_rs_o = 1'b0;
        uses_rt_o = 1'b0;
        wr        = 1'b0;
        dst_o     = '0;
        is_load_o = 1'b0;
        is_halt_o = 1'b0;
        illegal_o = 1'b0;
        if (opcode_i <= OP_W'(OP_SLTI)) begin
            wr        = 1'b1;
            uses_rs_o = 1'b1;
            if (!opcode_i[0]) begin
                uses_rt_o = 1'b1;
                dst_o     = rd_i;
            end else begin
                dst_o = rt_i;
            end
        end else begin
            unique case (opcode_i)
                OP_W'(OP_LDW): begin
                    wr        = 1'b1;
                    uses_rs_o = 1'b1;
                    is_load_o = 1'b1;
                    dst_o     = rt_i;
                end
                OP_W'(OP_STW),
                OP_W'(OP_BEQ): begin
                    uses_rs_o = 1'b1;
                    uses_rt_o = 1'b1;
                end
                OP_W'(OP_BZ),
                OP_W'(OP_JR): uses_rs_o = 1'b1;
                OP_W'(OP_HALT): is_halt_o = 1'b1;
                default: illegal_o = 1'b1;
            endcase
        end
    end

    // A write to $0 is discarded, so it can never be a hazard source.
    assign wr_en_o = wr && (dst_o != '0);

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Hazard/sequencing controller for a 5-stage MIPS pipeline.
// Tracks EX/MEM/WB stage records, decides stalls, bubbles, branch flushes,
// registered EX forward selects, and the HALT drain sequence.
// Ports: clk, rst_n (sync, active-low), bus (mips_pipe_ctrl_if.slave).
module mips_pipe_ctrl
    import mips_pkg::*;
#(
    parameter bit          FWD_EN = 1'b1,
    parameter int unsigned CNT_W  = 32
) (
    input logic             clk,
    input logic             rst_n,
    mips_pipe_ctrl_if.slave bus
);

    logic             dec_uses_rs, dec_uses_rt, dec_wr_en;
    logic             dec_is_load, dec_is_halt, dec_illegal;
    logic [REG_W-1:0] dec_dst;

    mips_src_decode u_dec (
        .opcode_i  (bus.id_opcode),
        .rt_i      (bus.id_rt),
        .rd_i      (bus.id_rd),
        .uses_rs_o (dec_uses_rs),
        .uses_rt_o (dec_uses_rt),
        .wr_en_o   (dec_wr_en),
        .dst_o     (dec_dst),
        .is_load_o (dec_is_load),
        .is_halt_o (dec_is_halt),
        .illegal_o (dec_illegal)
    );

    stage_rec_t       ex_q, mem_q, wb_q, ex_d, id_rec;
    ctrl_state_e      state_q, state_d;
    fwd_sel_e         rs_sel_q, rt_sel_q, rs_sel, rt_sel;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q, stall_q, flush_q;

    logic rs_ex, rs_mem, rt_ex, rt_mem, hazard;
    logic hold, flush, bubble, stall_ev, flush_ev, load_id;

    assign id_rec = '{valid: 1'b1, wr_en: dec_wr_en, is_load: dec_is_load,
                      is_halt: dec_is_halt, dst: dec_dst};

    // RAW detection and forward choice; the EX match is the youngest producer.
    always_comb begin
        rs_ex  = dec_uses_rs && rec_hit(ex_q,  bus.id_rs);
        rs_mem = dec_uses_rs && rec_hit(mem_q, bus.id_rs);
        rt_ex  = dec_uses_rt && rec_hit(ex_q,  bus.id_rt);
        rt_mem = dec_uses_rt && rec_hit(mem_q, bus.id_rt);
        hazard = 1'b0;
        rs_sel = FWD_RF;
        rt_sel = FWD_RF;
        if (FWD_EN) begin
            hazard = ex_q.is_load && (rs_ex || rt_ex);
            if (rs_ex)       rs_sel = FWD_EXMEM;
            else if (rs_mem) rs_sel = FWD_MEMWB;
            if (rt_ex)       rt_sel = FWD_EXMEM;
            else if (rt_mem) rt_sel = FWD_MEMWB;
        end else begin
            hazard = rs_ex || rs_mem || rt_ex || rt_mem;
        end
        hazard = hazard && bus.id_valid;
    end

    // Controller FSM: redirect beats stall beats HALT entry.
    always_comb begin
        state_d  = state_q;
        hold     = 1'b0;
        flush    = 1'b0;
        bubble   = 1'b0;
        stall_ev = 1'b0;
        flush_ev = 1'b0;
        load_id  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.ex_redirect) begin
                    flush    = 1'b1;
                    bubble   = 1'b1;
                    flush_ev = 1'b1;
                end else if (hazard) begin
                    hold     = 1'b1;
                    bubble   = 1'b1;
                    stall_ev = 1'b1;
                end else if (bus.id_valid) begin
                    load_id = 1'b1;
                    if (dec_is_halt) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                hold   = 1'b1;
                bubble = 1'b1;
                if (wb_q.valid && wb_q.is_halt) state_d = ST_HALTED;
            end
            ST_HALTED: begin
                hold   = 1'b1;
                bubble = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign ex_d = load_id ? id_rec : '0;

    // Stage records, registered selects, sticky flag and saturating counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            rs_sel_q  <= FWD_RF;
            rt_sel_q  <= FWD_RF;
            illegal_q <= 1'b0;
            retired_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q  <= state_d;
            ex_q     <= ex_d;
            mem_q    <= ex_q;
            wb_q     <= mem_q;
            rs_sel_q <= load_id ? rs_sel : FWD_RF;
            rt_sel_q <= load_id ? rt_sel : FWD_RF;
            if (bus.id_valid && dec_illegal) illegal_q <= 1'b1;
            if (state_q != ST_HALTED) begin
                if (wb_q.valid && !wb_q.is_halt && retired_q != '1)
                    retired_q <= retired_q + CNT_W'(1);
                if (stall_ev && stall_q != '1) stall_q <= stall_q + CNT_W'(1);
                if (flush_ev && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_if      = hold;
    assign bus.stall_id      = hold;
    assign bus.flush_id      = flush;
    assign bus.bubble_ex     = bubble;
    assign bus.ex_fwd_rs_sel = rs_sel_q;
    assign bus.ex_fwd_rt_sel = rt_sel_q;
    assign bus.halted        = (state_q == ST_HALTED);
    assign bus.illegal_op    = illegal_q;
    assign bus.retired_cnt   = retired_q;
    assign bus.stall_cnt     = stall_q;
    assign bus.flush_cnt     = flush_q;

endmodule
